// File: rtl/axis_wr_burst_ctrl.sv
// Write-side burst scheduler for the AXI-Stream to AXI4 bridge.
// A write command (start address, beat count) is split into AXI4 INCR bursts.
// Each burst is capped at MAX_BURST beats and never crosses a 4 KB page.
// Only one burst is outstanding at a time: AW, then W beats, then B.
module axis_wr_burst_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [15:0]         cmd_beats,
    output logic                busy,
    output logic                done,
    output logic                err,

    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [DATA_W-1:0]   s_tdata,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,

    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,

    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp
);

    localparam int BYTES      = DATA_W / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [15:0]         rem_q, rem_d;
    logic [8:0]          blen_q, blen_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [7:0]          awlen_q, awlen_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    // Burst length: the smallest of remaining beats, MAX_BURST and beats left in the 4 KB page.
    function automatic logic [8:0] calc_blen(input logic [11:0] offset, input logic [15:0] remaining);
        logic [12:0] room;
        logic [16:0] lim;
        room = (13'd4096 - {1'b0, offset}) >> BYTE_SHIFT;
        lim  = 17'(MAX_BURST);
        if ({4'b0000, room} < lim) begin
            lim = {4'b0000, room};
        end
        if ({1'b0, remaining} < lim) begin
            lim = {1'b0, remaining};
        end
        return 9'(lim);
    endfunction

    // Next-state logic, handshake outputs and burst bookkeeping; AW payload is loaded on entry to ADDR.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        blen_d     = blen_q;
        beat_cnt_d = beat_cnt_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        err_d      = err_q;
        done_d     = 1'b0;

        cmd_ready  = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        s_tready   = 1'b0;
        m_wlast    = 1'b0;
        m_bready   = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_d = cmd_addr;
                    rem_d      = (cmd_beats == 16'd0) ? 16'd1 : cmd_beats;
                    err_d      = 1'b0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    beat_cnt_d = 9'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                m_wvalid = s_tvalid;
                s_tready = m_wready;
                m_wlast  = (beat_cnt_q == blen_q - 9'd1);
                if (s_tvalid && m_wready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (m_wlast) begin
                        rem_d      = rem_q - 16'(blen_q);
                        cur_addr_d = cur_addr_q + (ADDR_W'(blen_q) << BYTE_SHIFT);
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    m_bready = 1'b1;
                    if (m_bvalid) begin
                        if (m_bresp != 2'b00) begin
                            err_d = 1'b1;
                        end
                        if (rem_q == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ADDR;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ADDR && state_q != ADDR) begin
            blen_d   = calc_blen(cur_addr_d[11:0], rem_d);
            awaddr_d = cur_addr_d;
            awlen_d  = 8'(blen_d - 9'd1);
        end
    end

    // State and datapath registers; reset drops everything back to an idle, error-free block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            blen_q     <= '0;
            beat_cnt_q <= '0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            blen_q     <= blen_d;
            beat_cnt_q <= beat_cnt_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = 3'(BYTE_SHIFT);
    assign m_awburst = 2'b01;
    assign m_wdata   = s_tdata;
    assign m_wstrb   = '1;

endmodule

// File: tb/tb_axis_wr_burst_ctrl.sv
// Scoreboard bench for axis_wr_burst_ctrl: a reference model splits each
// command into bursts and queues the expected AW, W and done/err responses;
// a monitor pops and compares them as the DUT presents handshakes.
module tb_axis_wr_burst_ctrl;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 16;
    localparam int BYTES     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_addr;
    logic [15:0]       cmd_beats;
    logic              busy;
    logic              done;
    logic              err;
    logic              s_tvalid;
    logic              s_tready;
    logic [63:0]       s_tdata;
    logic              m_awvalid;
    logic              m_awready;
    logic [31:0]       m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid;
    logic              m_wready;
    logic [63:0]       m_wdata;
    logic [7:0]        m_wstrb;
    logic              m_wlast;
    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;

    axis_wr_burst_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_beats (cmd_beats),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),
        .m_awsize  (m_awsize),
        .m_awburst (m_awburst),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_bresp   (m_bresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } w_t;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    logic        exp_done[$];
    logic [63:0] stream_q[$];
    logic [1:0]  bresp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int stall_pct   = 0;
    int b_pending   = 0;
    int b_left      = 0;
    int w_hs_count  = 0;

    logic        prev_awv;
    logic        prev_awr;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    logic        accept_prev;
    logic        last_b_prev;
    logic        done_prev;

    // One comparison: counted, and reported when the DUT value differs from the expectation.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A monitor or wait event that should never occur; counted as a failed comparison.
    task automatic reportFail(input string name, input string what);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: %s at %0t", name, what, $time);
    endtask

    // Every output that must sit at its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_awvalid"}, m_awvalid, 0);
        checkOutput({tag, "_wvalid"}, m_wvalid, 0);
        checkOutput({tag, "_wlast"}, m_wlast, 0);
        checkOutput({tag, "_bready"}, m_bready, 0);
        checkOutput({tag, "_s_tready"}, s_tready, 0);
        checkOutput({tag, "_awaddr"}, m_awaddr, 0);
        checkOutput({tag, "_awlen"}, m_awlen, 0);
    endtask

    // Reference model: split the command into bursts, queue expectations, then present it to the DUT.
    task automatic issueCommand(input logic [31:0] addr, input logic [15:0] beats, input int err_mode);
        logic [31:0] a;
        logic [11:0] off;
        int          rem;
        int          blen;
        int          room;
        int          nb;
        logic        any_err;
        logic [1:0]  r;
        aw_t         ea;
        w_t          ew;
        int          waited;

        @(posedge clk);
        #1;
        a       = addr;
        rem     = (beats == 16'd0) ? 1 : int'(beats);
        nb      = 0;
        any_err = 1'b0;
        while (rem > 0) begin
            off  = a[11:0];
            room = (4096 - int'(off)) / BYTES;
            blen = rem;
            if (blen > MAX_BURST) blen = MAX_BURST;
            if (blen > room) blen = room;
            ea.addr = a;
            ea.len  = 8'(blen - 1);
            exp_aw.push_back(ea);
            for (int i = 0; i < blen; i++) begin
                ew.data = {$urandom, $urandom};
                ew.last = (i == blen - 1);
                stream_q.push_back(ew.data);
                exp_w.push_back(ew);
            end
            r = 2'b00;
            if (err_mode == 1 && nb == 0) begin
                r = 2'b10;
            end else if (err_mode == 2 && $urandom_range(0, 9) == 0) begin
                r = 2'($urandom_range(1, 3));
            end
            any_err = any_err | (r != 2'b00);
            bresp_q.push_back(r);
            a   = a + 32'(blen * BYTES);
            rem = rem - blen;
            nb++;
        end
        exp_done.push_back(any_err);
        b_left = nb;

        cmd_addr  = addr;
        cmd_beats = beats;
        cmd_valid = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!cmd_ready) reportFail("cmd_accept_timeout", "cmd_ready never seen");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for the command to complete, then make sure nothing expected is left over.
    task automatic waitDone(input string name);
        int cycles;
        cycles = 0;
        while (exp_done.size() > 0 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        if (exp_done.size() > 0) reportFail({name, "_done_timeout"}, "done never pulsed");
        repeat (3) @(negedge clk);
        checkOutput({name, "_aw_left"}, 64'(exp_aw.size()), 0);
        checkOutput({name, "_w_left"}, 64'(exp_w.size()), 0);
        checkOutput({name, "_stream_left"}, 64'(stream_q.size()), 0);
        checkOutput({name, "_idle_ready"}, cmd_ready, 1);
    endtask

    // A full command: model, issue, and wait for its completion.
    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [15:0] beats,
                                 input int err_mode);
        issueCommand(addr, beats, err_mode);
        waitDone(name);
    endtask

    // Assert reset just after a clock edge and flush every scoreboard queue.
    task automatic applyReset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        s_tvalid  = 1'b0;
        m_bvalid  = 1'b0;
        b_pending = 0;
        b_left    = 0;
        exp_aw.delete();
        exp_w.delete();
        exp_done.delete();
        stream_q.delete();
        bresp_q.delete();
    endtask

    // Slave/source models: stream source, AW/W ready and B responder with random backpressure.
    initial begin
        logic s_hs;
        logic b_hs;
        logic wl_hs;
        forever begin
            @(negedge clk);
            s_hs  = s_tvalid && s_tready;
            b_hs  = m_bvalid && m_bready;
            wl_hs = m_wvalid && m_wready && m_wlast;
            @(posedge clk);
            #1;
            if (s_hs && stream_q.size() > 0) void'(stream_q.pop_front());
            if (wl_hs) b_pending++;
            if (b_hs) begin
                m_bvalid = 1'b0;
                if (b_pending > 0) b_pending--;
            end
            m_awready = ($urandom_range(0, 99) >= stall_pct);
            m_wready  = ($urandom_range(0, 99) >= stall_pct);
            s_tvalid  = (stream_q.size() > 0) && ($urandom_range(0, 99) >= stall_pct);
            s_tdata   = (stream_q.size() > 0) ? stream_q[0] : 64'd0;
            if (!m_bvalid && b_pending > 0 && $urandom_range(0, 99) >= stall_pct) begin
                m_bvalid = 1'b1;
                m_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
            end
        end
    end

    // Monitor: compares each DUT handshake against the scoreboard queues and checks protocol timing.
    initial begin
        aw_t  ea;
        w_t   ew;
        logic ed;
        logic last_b;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_awv    = 1'b0;
                prev_awr    = 1'b0;
                accept_prev = 1'b0;
                last_b_prev = 1'b0;
                done_prev   = 1'b0;
            end else begin
                if (m_awvalid || m_bready || cmd_ready) begin
                    checkOutput("s_tready_outside_data", s_tready, 0);
                    checkOutput("wvalid_outside_data", m_wvalid, 0);
                end
                if (prev_awv && !prev_awr) begin
                    checkOutput("aw_hold_valid", m_awvalid, 1);
                    checkOutput("aw_hold_addr", m_awaddr, prev_addr);
                    checkOutput("aw_hold_len", m_awlen, prev_len);
                end
                if (accept_prev) begin
                    checkOutput("err_clear_on_accept", err, 0);
                    checkOutput("awvalid_after_accept", m_awvalid, 1);
                end
                if (done || last_b_prev) begin
                    checkOutput("done_timing", done, last_b_prev);
                    if (done) begin
                        checkOutput("busy_during_done", busy, 1);
                        if (exp_done.size() == 0) begin
                            reportFail("unexpected_done", "done pulse with no command pending");
                        end else begin
                            ed = exp_done.pop_front();
                            checkOutput("err_at_done", err, ed);
                        end
                    end
                end
                if (done_prev) begin
                    checkOutput("ready_after_done", cmd_ready, 1);
                    checkOutput("busy_after_done", busy, 0);
                end
                if (m_awvalid && m_awready) begin
                    checkOutput("awsize", m_awsize, 3);
                    checkOutput("awburst", m_awburst, 1);
                    if (exp_aw.size() == 0) begin
                        reportFail("unexpected_aw", "AW handshake not predicted");
                    end else begin
                        ea = exp_aw.pop_front();
                        checkOutput("awaddr", m_awaddr, ea.addr);
                        checkOutput("awlen", m_awlen, ea.len);
                    end
                end
                if (m_wvalid && m_wready) begin
                    w_hs_count++;
                    checkOutput("s_tready_pass", s_tready, 1);
                    checkOutput("wstrb", m_wstrb, 64'hFF);
                    if (exp_w.size() == 0) begin
                        reportFail("unexpected_w", "W beat not predicted");
                    end else begin
                        ew = exp_w.pop_front();
                        checkOutput("wdata", m_wdata, ew.data);
                        checkOutput("wlast", m_wlast, ew.last);
                    end
                end
                last_b = 1'b0;
                if (m_bvalid && m_bready) begin
                    if (b_left == 0) begin
                        reportFail("unexpected_b", "B accepted with no burst outstanding");
                    end else begin
                        b_left--;
                        last_b = (b_left == 0);
                    end
                end
                prev_awv    = m_awvalid;
                prev_awr    = m_awready;
                prev_addr   = m_awaddr;
                prev_len    = m_awlen;
                accept_prev = cmd_valid && cmd_ready;
                last_b_prev = last_b;
                done_prev   = done;
            end
        end
    end

    // Test sequence: directed cases, randomized backpressure, reset mid-burst.
    initial begin
        logic [31:0] tmp;
        logic [31:0] addr;
        int          base;
        int          waited;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        stall_pct = 0;
        applyStimulus("single_burst", 32'h0000_1000, 16'd8, 0);
        applyStimulus("max_split", 32'h0000_0000, 16'd40, 0);
        applyStimulus("cross_4k", 32'h0000_0FE0, 16'd10, 0);
        applyStimulus("slverr", 32'h0000_8000, 16'd32, 1);
        applyStimulus("addr_wrap", 32'hFFFF_FFC0, 16'd20, 0);

        stall_pct = 40;
        for (int n = 0; n < 24; n++) begin
            tmp = $urandom;
            if (n % 2 == 0) begin
                addr = (tmp & 32'hFFFF_F000) | (32'h0000_1000 - 32'($urandom_range(1, 64)) * 32'd8);
            end else begin
                addr = tmp & 32'hFFFF_FFF8;
            end
            applyStimulus("random", addr, 16'($urandom_range(0, 70)), 2);
        end

        stall_pct = 0;
        base = w_hs_count;
        issueCommand(32'h0000_3000, 16'd8, 0);
        waited = 0;
        while (w_hs_count < base + 3 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (w_hs_count < base + 3) reportFail("reset_wait_beats", "three W beats never seen");
        applyReset();
        #1;
        checkResetValues("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("post_reset");
        applyStimulus("zero_beats", 32'h0000_2000, 16'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
